// File: rtl/uart_ctrl_if.sv
// CPU peripheral bus port of the UART controller: load/store strobes,
// address and data, plus the level interrupt request back to the CPU.
interface uart_ctrl_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output rd, wr, addr, wdata, input rdata, irq);
  modport slave  (input rd, wr, addr, wdata, output rdata, irq);
endinterface

// File: rtl/uart_ctrl.sv
// Memory-mapped 8N1 UART (LSB first) with TXD/RXD/CON registers,
// independent TX and RX state machines and a level interrupt.
//
// state   | TX meaning                 | RX meaning
// IDLE    | line high, waiting on TXD  | waiting for falling edge on rx
// START   | driving start bit (0)      | half-bit wait, glitch check
// DATA    | driving bits 0..7          | sampling 8 bits mid-bit
// STOP    | driving stop bit (1)       | sampling stop bit
module uart_ctrl #(
  parameter int          CLKS_PER_BIT = 10417,
  parameter logic [31:0] ADDR_TXD     = 32'h4000_0018,
  parameter logic [31:0] ADDR_RXD     = 32'h4000_001C,
  parameter logic [31:0] ADDR_CON     = 32'h4000_0020
) (
  input  logic         clk,
  input  logic         reset,
  uart_ctrl_if.slave   bus,
  input  logic         uart_rx,
  output logic         uart_tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic sel_txd, sel_rxd, sel_con;
  logic rd_rxd, rd_con, wr_txd, wr_con;

  assign sel_txd = (bus.addr == ADDR_TXD);
  assign sel_rxd = (bus.addr == ADDR_RXD);
  assign sel_con = (bus.addr == ADDR_CON);
  assign rd_rxd  = bus.rd & sel_rxd;
  assign rd_con  = bus.rd & sel_con;
  assign wr_txd  = bus.wr & sel_txd;
  assign wr_con  = bus.wr & sel_con;

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:8];

  // ---------------- transmitter ----------------
  state_t           tx_state, tx_state_nxt;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift, txd_reg;
  logic             tx_tc, tx_load, tx_finish, tx_busy;

  assign tx_tc   = (tx_cnt == '0);
  assign tx_busy = (tx_state != S_IDLE);

  always_comb begin
    tx_state_nxt = tx_state;
    tx_load      = 1'b0;
    tx_finish    = 1'b0;
    case (tx_state)
      S_IDLE:  if (wr_txd) begin
                 tx_state_nxt = S_START;
                 tx_load      = 1'b1;
               end
      S_START: if (tx_tc) tx_state_nxt = S_DATA;
      S_DATA:  if (tx_tc && tx_bit == 3'd7) tx_state_nxt = S_STOP;
      S_STOP:  if (tx_tc) begin
                 tx_state_nxt = S_IDLE;
                 tx_finish    = 1'b1;
               end
      default: tx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_state <= S_IDLE;
    else        tx_state <= tx_state_nxt;
  end

  // uart_tx is loaded with the level of the bit period that starts on this edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd_reg  <= '0;
      uart_tx  <= 1'b1;
    end else if (tx_load) begin
      txd_reg  <= bus.wdata[7:0];
      tx_shift <= bus.wdata[7:0];
      tx_cnt   <= BIT_LAST;
      tx_bit   <= '0;
      uart_tx  <= 1'b0;
    end else if (tx_busy) begin
      if (tx_tc) begin
        tx_cnt <= BIT_LAST;
        case (tx_state)
          S_START: uart_tx <= tx_shift[0];
          S_DATA: begin
            tx_bit <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) begin
              uart_tx <= 1'b1;
            end else begin
              uart_tx  <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end
          default: uart_tx <= 1'b1;
        endcase
      end else begin
        tx_cnt <= tx_cnt - CNT_ONE;
      end
    end
  end

  // ---------------- receiver ----------------
  state_t           rx_state, rx_state_nxt;
  logic [1:0]       rx_sync;
  logic             rx_s, rx_prev, rx_fall;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift, rx_data;
  logic             rx_tc, rx_start, rx_shift_en, rx_stop_ok, rx_stop_bad;

  assign rx_s    = rx_sync[1];
  assign rx_fall = rx_prev & ~rx_s;
  assign rx_tc   = (rx_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_start     = 1'b0;
    rx_shift_en  = 1'b0;
    rx_stop_ok   = 1'b0;
    rx_stop_bad  = 1'b0;
    case (rx_state)
      S_IDLE:  if (rx_fall) begin
                 rx_state_nxt = S_START;
                 rx_start     = 1'b1;
               end
      S_START: if (rx_tc) rx_state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tc) begin
                 rx_shift_en = 1'b1;
                 if (rx_bit == 3'd7) rx_state_nxt = S_STOP;
               end
      S_STOP:  if (rx_tc) begin
                 rx_state_nxt = S_IDLE;
                 rx_stop_ok   = rx_s;
                 rx_stop_bad  = ~rx_s;
               end
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= S_IDLE;
    else        rx_state <= rx_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (rx_start) begin
      rx_cnt <= HALF_LAST;
      rx_bit <= '0;
    end else if (rx_state != S_IDLE) begin
      rx_cnt <= rx_tc ? BIT_LAST : rx_cnt - CNT_ONE;
      if (rx_shift_en) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  // ---------------- status, control, interrupt ----------------
  logic tx_ie, rx_ie, tx_done, rx_valid, frame_err, overrun, irq_q;

  // set events are OR-ed in after the clear so a coincident set wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      tx_ie     <= 1'b0;
      rx_ie     <= 1'b0;
      tx_done   <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (rx_stop_ok) rx_data <= rx_shift;
      if (wr_con) {rx_ie, tx_ie} <= bus.wdata[1:0];
      tx_done   <= tx_finish | (tx_done & ~rd_con);
      rx_valid  <= rx_stop_ok | (rx_valid & ~rd_rxd);
      frame_err <= rx_stop_bad | (frame_err & ~rd_con);
      overrun   <= (rx_stop_ok & rx_valid) | (overrun & ~rd_con);
      irq_q     <= (tx_done & tx_ie) | (rx_valid & rx_ie);
    end
  end

  assign bus.irq = irq_q;

  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      if (sel_txd)      bus.rdata = {24'b0, txd_reg};
      else if (sel_rxd) bus.rdata = {24'b0, rx_data};
      else if (sel_con) bus.rdata = {25'b0, tx_busy, overrun, frame_err,
                                     rx_valid, tx_done, rx_ie, tx_ie};
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed self-checking bench for uart_ctrl at 16 clocks per bit:
// TX waveform capture, RX frame driving, flag and interrupt behaviour.
module tb_uart_ctrl;

  localparam int          CPB   = 16;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic uart_rx = 1'b1;
  logic uart_tx;

  int n_checks = 0;
  int n_errors = 0;

  uart_ctrl_if bus_if ();

  uart_ctrl #(
    .CLKS_PER_BIT (CPB),
    .ADDR_TXD     (A_TXD),
    .ADDR_RXD     (A_RXD),
    .ADDR_CON     (A_CON)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.addr  = a;
    bus_if.wdata = d;
    bus_if.wr    = 1'b1;
    @(negedge clk);
    bus_if.wr    = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    @(negedge clk);
    bus_if.addr = a;
    bus_if.rd   = 1'b1;
    #1 d = bus_if.rdata;
    @(negedge clk);
    bus_if.rd   = 1'b0;
    check(tag, d, exp);
  endtask

  // Call right after bus_write to TXD; compares each 16-cycle bit slot exactly.
  task automatic tx_capture(input logic [7:0] b, input string tag);
    logic [15:0] seen;
    logic [15:0] want;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < CPB; j++) begin
        seen[j] = uart_tx;
        @(negedge clk);
      end
      if (i == 0)      want = 16'h0000;
      else if (i == 9) want = 16'hFFFF;
      else             want = {16{b[i-1]}};
      check($sformatf("%s_bit%0d", tag, i), {16'h0, seen}, {16'h0, want});
    end
    check({tag, "_idle"}, {31'b0, uart_tx}, 32'h1);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  initial begin
    bus_if.rd    = 1'b0;
    bus_if.wr    = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, uart_tx}, 32'h1);
    check("rst_irq", {31'b0, bus_if.irq}, 32'h0);
    reset = 1'b1;
    bus_if.addr = A_CON;
    @(negedge clk);
    check("rdata_no_rd", bus_if.rdata, 32'h0);
    read_check("rst_con", A_CON, 32'h0);
    read_check("rst_rxd", A_RXD, 32'h0);
    read_check("rst_txd", A_TXD, 32'h0);
    read_check("bad_addr", 32'h4000_0024, 32'h0);

    // 1: transmit 0xA5, tx_done clear-on-read
    bus_write(A_TXD, 32'h0000_00A5);
    tx_capture(8'hA5, "t1");
    read_check("t1_con_done", A_CON, 32'h04);
    read_check("t1_con_clr", A_CON, 32'h00);

    // 2: receive 0x3C with rx_ie, irq follows rx_valid
    bus_write(A_CON, 32'h2);
    rx_send(8'h3C, 1'b1);
    check("t2_irq_set", {31'b0, bus_if.irq}, 32'h1);
    read_check("t2_rxd", A_RXD, 32'h3C);
    check("t2_irq_lag", {31'b0, bus_if.irq}, 32'h1);
    @(negedge clk);
    check("t2_irq_clr", {31'b0, bus_if.irq}, 32'h0);
    read_check("t2_con", A_CON, 32'h02);

    // 3: TXD write while busy is ignored
    bus_write(A_CON, 32'h0);
    bus_write(A_TXD, 32'h0000_005A);
    fork
      tx_capture(8'h5A, "t3");
      begin
        repeat (40) @(negedge clk);
        bus_write(A_TXD, 32'h0000_0011);
        read_check("t3_busy", A_CON, 32'h40);
        read_check("t3_txd_mid", A_TXD, 32'h5A);
      end
    join
    read_check("t3_con_done", A_CON, 32'h04);
    read_check("t3_txd_end", A_TXD, 32'h5A);

    // 4: overrun, then framing error
    rx_send(8'h01, 1'b1);
    rx_send(8'h02, 1'b1);
    read_check("t4_con_ovr", A_CON, 32'h28);
    read_check("t4_rxd", A_RXD, 32'h02);
    read_check("t4_con_clr", A_CON, 32'h00);
    rx_send(8'h55, 1'b0);
    read_check("t4_con_ferr", A_CON, 32'h10);
    read_check("t4_rxd_keep", A_RXD, 32'h02);

    // 5: short glitch, then full duplex
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    read_check("t5_glitch", A_CON, 32'h00);
    bus_write(A_TXD, 32'h0000_00FF);
    fork
      tx_capture(8'hFF, "t5");
      rx_send(8'h81, 1'b1);
    join
    read_check("t5_con", A_CON, 32'h0C);
    read_check("t5_rxd", A_RXD, 32'h81);

    // 6: CON writes only [1:0]; reset mid-frame
    bus_write(A_CON, 32'hFFFF_FFFF);
    read_check("t6_con_wr", A_CON, 32'h03);
    rx_send(8'h42, 1'b1);
    check("t6_irq_pre", {31'b0, bus_if.irq}, 32'h1);
    bus_write(A_TXD, 32'h0000_0000);
    repeat (60) @(negedge clk);
    check("t6_tx_low", {31'b0, uart_tx}, 32'h0);
    reset = 1'b0;
    #1;
    check("t6_tx_async", {31'b0, uart_tx}, 32'h1);
    check("t6_irq_rst", {31'b0, bus_if.irq}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    read_check("t6_con_rst", A_CON, 32'h00);
    read_check("t6_rxd_rst", A_RXD, 32'h00);
    bus_write(A_TXD, 32'h0000_00C3);
    tx_capture(8'hC3, "t6");
    read_check("t6_con_done", A_CON, 32'h04);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
